pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 132 +++++++++++++
 tb/tb_pipelined_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Valid/ready pipelined adder/subtractor: each stage adds one CHUNK-bit slice and
// passes its carry to the next stage, so a WIDTH-bit add completes in WIDTH/CHUNK cycles.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Per-stage state: valid, low-order sum so far, carry out, carried operands, carry into chunk MSB.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cry_q;
  logic [STAGES-1:0] cmsb_q;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];

  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] src_cry;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];

  logic [CHUNK:0]    add_w    [STAGES];
  logic [WIDTH-1:0]  nxt_sum  [STAGES];
  logic [STAGES-1:0] nxt_cry;
  logic [STAGES-1:0] nxt_cmsb;

  logic chain;
  logic accept;

  // A stage may load when it is empty or its occupant moves forward this cycle;
  // walking back from the output lets any bubble absorb backpressure.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the updated value.
    load  = '0;
    chain = !vld_q[LAST] || out_ready;
    load[LAST] = chain;
    for (int k = LAST - 1; k >= 0; k--) begin
      chain   = !vld_q[k] || chain;
      load[k] = chain;
    end
  end

  assign in_ready = rst_n && load[0];
  assign accept   = in_valid && in_ready;

  // Stage 0 takes the operands with subtraction folded into an inverted B and carry-in of 1.
  always_comb begin
    src_vld    = '0;
    src_cry    = '0;
    src_vld[0] = accept;
    src_cry[0] = in_sub | in_cin;
    src_a[0]   = in_a;
    src_b[0]   = in_sub ? ~in_b : in_b;
    src_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_cry[k] = cry_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_sum[k] = sum_q[k-1];
    end
  end

  always_comb begin
    nxt_cry  = '0;
    nxt_cmsb = '0;
    for (int k = 0; k < STAGES; k++) begin
      add_w[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
               + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, src_cry[k]};
      nxt_sum[k] = src_sum[k];
      nxt_sum[k][k*CHUNK +: CHUNK] = add_w[k][CHUNK-1:0];
      nxt_cry[k] = add_w[k][CHUNK];
      // The carry into the chunk MSB is recovered from the MSB sum bit and its two addend bits.
      nxt_cmsb[k] = add_w[k][CHUNK-1] ^ src_a[k][k*CHUNK+CHUNK-1] ^ src_b[k][k*CHUNK+CHUNK-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath arrays are reset along with the valid bits so the outputs read zero in reset.
      vld_q  <= '0;
      cry_q  <= '0;
      cmsb_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so all stages shift on the same edge.
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld_q[k] <= src_vld[k];
          if (src_vld[k]) begin
            sum_q[k]  <= nxt_sum[k];
            a_q[k]    <= src_a[k];
            b_q[k]    <= src_b[k];
            cry_q[k]  <= nxt_cry[k];
            cmsb_q[k] <= nxt_cmsb[k];
          end
        end
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = cry_q[LAST];
  assign out_ovf   = cmsb_q[LAST] ^ cry_q[LAST];
  assign out_zero  = out_valid && (sum_q[LAST] == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed corner cases, a randomized backpressured stream
// against an arithmetic reference model, mid-stream reset, and a 32-bit/8-bit-chunk instance.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_cout, out_ovf, out_zero;
  logic [15:0] in_a = '0, in_b = '0, out_sum;

  logic        w_in_valid = 1'b0, w_in_cin = 1'b0, w_in_sub = 1'b0, w_out_ready = 1'b0;
  logic        w_in_ready, w_out_valid, w_out_cout, w_out_ovf, w_out_zero;
  logic [31:0] w_in_a = '0, w_in_b = '0, w_out_sum;

  pipelined_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_cin(w_in_cin), .in_sub(w_in_sub),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sum(w_out_sum),
    .out_cout(w_out_cout), .out_ovf(w_out_ovf), .out_zero(w_out_zero)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t exp_q[$];
  res_t got_e;
  res_t held;
  logic hold_prev = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, carry from the unsigned sum, overflow from the signed range.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int   sr;
    int   ur;
    if (sub) begin
      sr = int'($signed(a)) - int'($signed(b));
      ur = int'(a) + 65536 - int'(b);
    end else begin
      sr = int'($signed(a)) + int'($signed(b)) + int'(cin);
      ur = int'(a) + int'(b) + int'(cin);
    end
    r.sum  = ur[15:0];
    r.cout = (ur >= 65536);
    r.ovf  = (sr > 32767) || (sr < -32768);
    r.zero = (ur[15:0] == 16'h0000);
    return r;
  endfunction

  // Scoreboard: pushes accepted beats, pops and compares consumed results, checks flow control.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !(exp_q.size() == 4 && !out_ready));
      if (hold_prev) check("hold_stable", {out_sum, out_cout, out_ovf, out_zero}, held);
      if (exp_q.size() == 0) check("valid_when_empty", out_valid, 1'b0);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        got_e = exp_q.pop_front();
        check("stream_sum",  out_sum,  got_e.sum);
        check("stream_cout", out_cout, got_e.cout);
        check("stream_ovf",  out_ovf,  got_e.ovf);
        check("stream_zero", out_zero, got_e.zero);
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
      hold_prev = out_valid && !out_ready;
      held      = {out_sum, out_cout, out_ovf, out_zero};
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez, input string tag);
    int lat;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_lat"},  lat, 4);
    check({tag, "_sum"},  out_sum, es);
    check({tag, "_cout"}, out_cout, ec);
    check({tag, "_ovf"},  out_ovf, eo);
    check({tag, "_zero"}, out_zero, ez);
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int n;
    int lat;
    logic acc;

    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b0);
    check("rst_out_sum",   out_sum,   16'h0);
    check("rst_flags",     {out_cout, out_ovf, out_zero}, 3'b000);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);

    send16(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 1'b0, "add_basic");
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "ripple");
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "pos_ovf");
    send16(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
    send16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");

    // Back-to-back random stream with random backpressure.
    @(posedge clk); #1;
    in_a = 16'($urandom); in_b = 16'($urandom);
    in_cin = 1'($urandom); in_sub = 1'($urandom); in_valid = 1'b1;
    out_ready = 1'($urandom);
    sent = 0;
    n = 0;
    while (sent < 20 && n < 500) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
      if (acc) begin
        sent++;
        in_a = 16'($urandom); in_b = 16'($urandom);
        in_cin = 1'($urandom); in_sub = 1'($urandom);
        if (sent == 20) in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) == 0);
    end
    check("stream_sent", sent, 20);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stream_drained", exp_q.size(), 0);

    // Fill three stages, then pulse reset for one cycle.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'b0; in_sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready",  in_ready,  1'b0);
    check("midrst_out_sum",   out_sum,   16'h0);
    check("midrst_flags",     {out_cout, out_ovf, out_zero}, 3'b000);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid, 1'b0);
    end
    send16(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "after_rst");

    // 32-bit instance with 8-bit chunks.
    @(posedge clk); #1;
    w_in_a = 32'hFFFF_FFFF; w_in_b = 32'h0000_0001; w_in_cin = 1'b0; w_in_sub = 1'b0;
    w_in_valid = 1'b1; w_out_ready = 1'b1;
    @(negedge clk);
    check("w_in_ready", w_in_ready, 1'b1);
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!w_out_valid && lat < 20);
    check("w_lat",  lat, 4);
    check("w_sum",  w_out_sum, 32'h0);
    check("w_cout", w_out_cout, 1'b1);
    check("w_ovf",  w_out_ovf, 1'b0);
    check("w_zero", w_out_zero, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("w_consumed", w_out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
